// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls,
// taken-branch flushes, memory-busy freezes, HALT, and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned CNT_W        = 16,
  parameter logic [5:0]  OP_NOP       = 6'h00,
  parameter logic [5:0]  OP_R_TYPE    = 6'h01,
  parameter logic [5:0]  OP_I_TYPE    = 6'h02,
  parameter logic [5:0]  OP_J_TYPE    = 6'h03,
  parameter logic [5:0]  OP_HALT      = 6'h3F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        id_ir,
  input  logic                    ex_valid,
  input  logic                    ex_is_load,
  input  logic [REG_ADDR_LEN-1:0] ex_rd_no,
  input  logic                    br_taken,
  input  logic                    mem_busy,
  output logic                    if_stall,
  output logic                    id_stall,
  output logic                    id_flush,
  output logic                    ex_bubble,
  output logic                    ex_hold,
  output logic                    halted,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, HALTED} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]        stall_cnt_q;

  logic [5:0]              opcode;
  logic [REG_ADDR_LEN-1:0] rs, rt;
  logic                    uses_rs, uses_rt, lu_hit;
  logic                    unused_ir_bits;

  assign opcode         = id_ir[31:26];
  assign rs             = id_ir[16 +: REG_ADDR_LEN];
  assign rt             = id_ir[11 +: REG_ADDR_LEN];
  assign unused_ir_bits = ^{id_ir[25:21], id_ir[10:0]};

  // J-type, NOP, HALT and any unrecognised opcode read no registers.
  assign uses_rs = (opcode == OP_R_TYPE) || (opcode == OP_I_TYPE);
  assign uses_rt = (opcode == OP_R_TYPE);
  assign lu_hit  = ex_valid && ex_is_load && (ex_rd_no != '0) &&
                   ((uses_rs && (rs == ex_rd_no)) || (uses_rt && (rt == ex_rd_no)));

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    id_flush  = 1'b0;
    ex_bubble = 1'b0;
    ex_hold   = 1'b0;
    halted    = 1'b0;
    if (state_q == HALTED) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
      halted    = 1'b1;
      ex_hold   = mem_busy;
    end else if (mem_busy) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_hold  = 1'b1;
    end else if (br_taken) begin
      id_flush  = 1'b1;
      ex_bubble = 1'b1;
      state_d   = RUN;
      lu_cnt_d  = '0;
    end else if (lu_cnt_q != '0) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
      lu_cnt_d  = lu_cnt_q - 3'd1;
      state_d   = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        lu_cnt_d = 3'(LOAD_LAT - 1);
        state_d  = LU_STALL;
      end
    end else if (opcode == OP_HALT) begin
      state_d = HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      if (if_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl, three parameterisations sharing stimulus.
module tb_hazard_ctrl;

  localparam logic [5:0] OP_NOP = 6'h00, OP_R = 6'h01, OP_I = 6'h02, OP_J = 6'h03, OP_HALT = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_ir;
  logic        ex_valid, ex_is_load, br_taken, mem_busy;
  logic [4:0]  ex_rd_no;

  logic [2:0]  if_s, id_s, fl_s, bb_s, hd_s, ht_s;
  logic [15:0] sc1, sc3;
  logic [3:0]  scs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd_no(ex_rd_no), .br_taken(br_taken), .mem_busy(mem_busy),
    .if_stall(if_s[0]), .id_stall(id_s[0]), .id_flush(fl_s[0]), .ex_bubble(bb_s[0]),
    .ex_hold(hd_s[0]), .halted(ht_s[0]), .stall_cnt(sc1));

  hazard_ctrl #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd_no(ex_rd_no), .br_taken(br_taken), .mem_busy(mem_busy),
    .if_stall(if_s[1]), .id_stall(id_s[1]), .id_flush(fl_s[1]), .ex_bubble(bb_s[1]),
    .ex_hold(hd_s[1]), .halted(ht_s[1]), .stall_cnt(sc3));

  hazard_ctrl #(.LOAD_LAT(2), .CNT_W(4)) us (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd_no(ex_rd_no), .br_taken(br_taken), .mem_busy(mem_busy),
    .if_stall(if_s[2]), .id_stall(id_s[2]), .id_flush(fl_s[2]), .ex_bubble(bb_s[2]),
    .ex_hold(hd_s[2]), .halted(ht_s[2]), .stall_cnt(scs));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op, input int rs, input int rt);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op;
    w[20:16] = 5'(rs);
    w[15:11] = 5'(rt);
    return w;
  endfunction

  // Behavioural model: per instance, halted flag, remaining extra stall cycles, stall count.
  int LAT[3]  = '{1, 3, 2};
  int MAXC[3] = '{65535, 65535, 15};
  bit m_halt[3];
  int m_pend[3];
  int m_cnt[3];

  function automatic bit reads_reg(input logic [31:0] ir, input logic [4:0] r);
    case (ir[31:26])
      OP_R:    return (ir[20:16] == r) || (ir[15:11] == r);
      OP_I:    return ir[20:16] == r;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int act_cnt;
      act_cnt = (k == 0) ? int'(sc1) : (k == 1) ? int'(sc3) : int'(scs);
      if (rst) begin
        chk($sformatf("rst_halted[%0d]", k), int'(ht_s[k]), 0);
        chk($sformatf("rst_cnt[%0d]", k), act_cnt, 0);
        m_halt[k] = 1'b0;
        m_pend[k] = 0;
        m_cnt[k]  = 0;
      end else begin
        bit e_if, e_fl, e_bb, e_hd, e_ht, hit;
        e_if = 0; e_fl = 0; e_bb = 0; e_hd = 0; e_ht = 0;
        hit = ex_valid && ex_is_load && (ex_rd_no != 0) && reads_reg(id_ir, ex_rd_no);
        chk($sformatf("cnt[%0d]", k), act_cnt, m_cnt[k]);
        if (m_halt[k]) begin
          e_if = 1; e_bb = 1; e_ht = 1; e_hd = mem_busy;
        end else if (mem_busy) begin
          e_if = 1; e_hd = 1;
        end else if (br_taken) begin
          e_fl = 1; e_bb = 1; m_pend[k] = 0;
        end else if (m_pend[k] > 0) begin
          e_if = 1; e_bb = 1; m_pend[k]--;
        end else if (hit) begin
          e_if = 1; e_bb = 1; m_pend[k] = LAT[k] - 1;
        end else if (id_ir[31:26] == OP_HALT) begin
          m_halt[k] = 1'b1;
        end
        chk($sformatf("if_stall[%0d]", k), int'(if_s[k]), int'(e_if));
        chk($sformatf("id_stall[%0d]", k), int'(id_s[k]), int'(e_if));
        chk($sformatf("id_flush[%0d]", k), int'(fl_s[k]), int'(e_fl));
        chk($sformatf("ex_bubble[%0d]", k), int'(bb_s[k]), int'(e_bb));
        chk($sformatf("ex_hold[%0d]", k), int'(hd_s[k]), int'(e_hd));
        chk($sformatf("halted[%0d]", k), int'(ht_s[k]), int'(e_ht));
        if (e_if && m_cnt[k] < MAXC[k]) m_cnt[k]++;
      end
    end
  end

  task automatic idle_inputs();
    id_ir = '0; ex_valid = 0; ex_is_load = 0; ex_rd_no = '0; br_taken = 0; mem_busy = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_hazard(input int rd, input logic [31:0] ir);
    ex_valid = 1; ex_is_load = 1; ex_rd_no = 5'(rd); id_ir = ir;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Load-use, single bubble.
    do_reset();
    load_hazard(5, mk_ir(OP_R, 1, 5));
    #2;
    chk("lu1_if", int'(if_s[0]), 1);
    chk("lu1_id", int'(id_s[0]), 1);
    chk("lu1_bubble", int'(bb_s[0]), 1);
    chk("lu1_flush", int'(fl_s[0]), 0);
    step();
    ex_is_load = 0;
    #2;
    chk("lu1_after_if", int'(if_s[0]), 0);
    chk("lu1_after_bubble", int'(bb_s[0]), 0);
    chk("lu1_cnt", int'(sc1), 1);

    // No false hazards.
    do_reset();
    load_hazard(0, mk_ir(OP_R, 0, 0));
    #2 chk("rd0_no_stall", int'(if_s[0]), 0);
    step();
    load_hazard(7, mk_ir(OP_I, 3, 7));
    #2 chk("itype_rt_no_stall", int'(if_s[1]), 0);
    step();
    load_hazard(7, mk_ir(OP_J, 7, 7));
    #2 chk("jtype_no_stall", int'(if_s[1]), 0);

    // LOAD_LAT=3: three stall cycles.
    do_reset();
    load_hazard(9, mk_ir(OP_R, 9, 0));
    #2 chk("lu3_c1", int'(if_s[1]), 1);
    step();
    ex_valid = 0;
    #2 chk("lu3_c2", int'(bb_s[1]), 1);
    step();
    #2 chk("lu3_c3", int'(if_s[1]), 1);
    step();
    #2 chk("lu3_c4", int'(if_s[1]), 0);
    chk("lu3_cnt", int'(sc3), 3);

    // LOAD_LAT=3 with a taken branch in the 2nd cycle.
    do_reset();
    load_hazard(9, mk_ir(OP_R, 9, 0));
    step();
    ex_valid = 0; br_taken = 1;
    #2;
    chk("lu3br_flush", int'(fl_s[1]), 1);
    chk("lu3br_if", int'(if_s[1]), 0);
    step();
    br_taken = 0;
    #2 chk("lu3br_after", int'(if_s[1]), 0);

    // mem_busy freeze inside LU_STALL.
    do_reset();
    load_hazard(9, mk_ir(OP_R, 9, 0));
    step();
    ex_valid = 0; mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("mb_hold", int'(hd_s[1]), 1);
      chk("mb_bubble", int'(bb_s[1]), 0);
      step();
    end
    mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      #2 chk("mb_resume", int'(bb_s[1]), 1);
      step();
    end
    #2 chk("mb_done", int'(if_s[1]), 0);
    chk("mb_cnt", int'(sc3), 7);

    // HALT persistence and asynchronous exit.
    do_reset();
    id_ir = mk_ir(OP_HALT, 0, 0);
    #2 chk("halt_accept", int'(if_s[0]), 0);
    step();
    id_ir = mk_ir(OP_NOP, 0, 0);
    for (int i = 0; i < 100; i++) begin
      #2;
      chk("halt_flag", int'(ht_s[0]), 1);
      chk("halt_stall", int'(if_s[0]), 1);
      step();
    end
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_flag", int'(ht_s[0]), 0);
    chk("halt_rst_cnt", int'(sc1), 0);

    // Saturation of a 4-bit counter.
    do_reset();
    mem_busy = 1;
    repeat (20) step();
    #2 chk("sat_cnt", int'(scs), 15);
    chk("sat_wide_cnt", int'(sc1), 20);
    mem_busy = 0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int sel;
      step();
      rst = ($urandom_range(0, 149) == 0);
      sel = $urandom_range(0, 99);
      op = (sel < 35) ? OP_R : (sel < 65) ? OP_I : (sel < 80) ? OP_J :
           (sel < 90) ? OP_NOP : (sel < 91) ? OP_HALT : 6'($urandom);
      id_ir      = mk_ir(op, $urandom_range(0, 7), $urandom_range(0, 7));
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_is_load = ($urandom_range(0, 1) != 0);
      ex_rd_no   = 5'($urandom_range(0, 7));
      br_taken   = ($urandom_range(0, 9) == 0);
      mem_busy   = ($urandom_range(0, 7) == 0);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Decodes the instruction entering ID and compares it against EX/MEM status.
- Drives the IF/ID stall and flush controls: IsStall/IsFlush of the ID stage register, and the bubble/hold of EX.
- Handles load-use stalls, taken-branch flushes, memory-busy freezes and HALT, and keeps a saturating stall-cycle counter.

Parameters:
- WIDTH, 32, instruction/data width.
- REG_ADDR_LEN, 5, register-number width.
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_ir  in  WIDTH  instruction presented to ID. Fields: opcode [31:26], Rs [20:16], Rt [15:11].
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd_no  in  REG_ADDR_LEN  EX destination register.
- br_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_busy  in  1  MEM stage cannot complete this cycle.
- if_stall  out  1  hold PC and IF.
- id_stall  out  1  to ID IsStall.
- id_flush  out  1  to ID IsFlush (loads `NOP).
- ex_bubble  out  1  inject NOP into EX.
- ex_hold  out  1  freeze EX/MEM registers.
- halted  out  1  core halted.
- stall_cnt  out  CNT_W  cycles with if_stall=1, saturating.

Behaviour:
- State register: RUN, LU_STALL, HALTED. Reset → RUN, lu_cnt=0, stall_cnt=0. All outputs 0 during and after reset until inputs dictate otherwise.
- Outputs are combinational from state, lu_cnt and inputs, so pipeline registers act on the same edge.
- Source use by opcode (`ISA.v` macros):
  - `R_TYPE uses Rs and Rt.
  - `I_TYPE uses Rs only.
  - `J_TYPE, `NOP and `HALT use none.
- lu_hit = ex_valid & ex_is_load & ex_rd_no!=0 & ex_rd_no matches a used source.
- Priority in RUN/LU_STALL, highest first:
  1. mem_busy: if_stall=id_stall=ex_hold=1, bubble/flush=0. State and lu_cnt frozen.
  2. br_taken: id_flush=1, ex_bubble=1, if_stall=id_stall=0. Next state RUN, lu_cnt←0. A pending load-use or HALT in ID is discarded.
  3. LU_STALL (lu_cnt!=0): if_stall=id_stall=1, ex_bubble=1. lu_cnt←lu_cnt-1. Next state RUN when lu_cnt==1.
  4. RUN & lu_hit: if_stall=id_stall=1, ex_bubble=1. If LOAD_LAT>1: lu_cnt←LOAD_LAT-1, next state LU_STALL; otherwise stay in RUN.
  5. RUN & opcode==`HALT: ID accepts HALT this cycle (no stall). Next state HALTED.
  6. Otherwise all controls 0.
- HALTED: if_stall=id_stall=ex_bubble=1, halted=1. mem_busy still drives ex_hold so outstanding MEM completes. Exit only by rst.
- stall_cnt increments every cycle with if_stall=1 and saturates at all-ones. No wrap.
- Reset asserted mid-stall or in HALTED returns to RUN within the same cycle (asynchronous). Counter cleared.
- Simultaneous lu_hit and br_taken: flush wins, no stall, stall_cnt unchanged.

Test Plan:
- Load-use, LOAD_LAT=1: ex_valid=1, ex_is_load=1, ex_rd_no=5, id_ir R_TYPE with Rt=5 → one cycle of if_stall=id_stall=ex_bubble=1. Next cycle (ex_is_load=0) all 0. stall_cnt=1.
- No false hazard:
  - ex_rd_no=0 with Rs=0 → no stall.
  - I_TYPE with bits[15:11]=ex_rd_no=7, Rs≠7 → no stall.
  - J_TYPE whose target bits match → no stall.
- LOAD_LAT=3, R_TYPE Rs=ex_rd_no=9 → exactly 3 consecutive stall/bubble cycles, then RUN. Same setup with br_taken=1 in the 2nd cycle → that cycle id_flush=1, stall ends, state RUN.
- mem_busy held 4 cycles during LU_STALL (lu_cnt=2) → ex_hold=1 for 4 cycles, lu_cnt stays 2. After release, 2 more stall cycles follow. stall_cnt grows by 4+2 plus the cycle that entered LU_STALL.
- HALT in id_ir, no hazards → next cycle halted=1 with all stalls 1, persisting 100 cycles. Assert rst mid-HALTED → halted=0 and stall_cnt=0 immediately.
- Force stall_cnt near saturation with CNT_W=4 and sustained stall → holds at 15.
